// File: rtl/enc_arbiter_ctrl.sv
// Two-requester round-robin front end for a fixed-latency encryption engine.
// Holds the key, feeds one plaintext word at a time, and presents the tagged result until consumed.
module enc_arbiter_ctrl #(
   parameter int N   = 8,
   parameter int LAT = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         key_wr,
   input  logic [N-1:0] key_in,
   input  logic         req0_valid,
   input  logic [N-1:0] req0_data,
   input  logic         req1_valid,
   input  logic [N-1:0] req1_data,
   output logic         req0_ready,
   output logic         req1_ready,
   output logic [N-1:0] eng_key,
   output logic [N-1:0] eng_data,
   input  logic [N-1:0] eng_e_data,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic         out_id,
   input  logic         out_ready,
   output logic         busy,
   output logic         key_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_e       state_q, state_d;
   logic [N-1:0] key_q, key_d;
   logic         key_valid_q, key_valid_d;
   logic [N-1:0] eng_data_q, eng_data_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         last_grant_q, last_grant_d;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] out_data_q, out_data_d;
   logic         out_id_q, out_id_d;
   logic         key_err_q, key_err_d;
   logic         grant;
   logic         grant_id;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      key_valid_d  = key_valid_q;
      eng_data_d   = eng_data_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_id_d     = out_id_q;
      key_err_d    = 1'b0;
      grant        = 1'b0;
      grant_id     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // A key load owns the cycle; arbitration waits until the next one.
            if (key_wr) begin
               key_d       = key_in;
               key_valid_d = 1'b1;
            end else if (key_valid_q && (req0_valid || req1_valid)) begin
               grant        = 1'b1;
               grant_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
               eng_data_d   = grant_id ? req1_data : req0_data;
               out_id_d     = grant_id;
               last_grant_d = grant_id;
               cnt_d        = '0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            key_err_d = key_wr;
            if (cnt_q == LAT_C) begin
               out_data_d  = eng_e_data;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_HOLD: begin
            key_err_d = key_wr;
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         key_q        <= '0;
         key_valid_q  <= 1'b0;
         eng_data_q   <= '0;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_id_q     <= 1'b0;
         key_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         key_valid_q  <= key_valid_d;
         eng_data_q   <= eng_data_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_id_q     <= out_id_d;
         key_err_q    <= key_err_d;
      end
   end

   assign req0_ready = grant && !grant_id;
   assign req1_ready = grant && grant_id;
   assign eng_key    = key_q;
   assign eng_data   = eng_data_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_id     = out_id_q;
   assign busy       = (state_q != S_IDLE);
   assign key_err    = key_err_q;

endmodule
